dma_desc_queue: RTL
===================

Name: dma_desc_queue

Overview:
- Descriptor queue and issue sequencer between the DMA CSR front-end and the DMA transfer engine.
- Each one-cycle go pulse from the CSR block pushes one descriptor (src, dst, len, last) into a FIFO.
- The block hands descriptors one at a time to the engine over a valid/ready handshake, then waits for completion.
- Raises a sticky interrupt when a last-flagged descriptor completes, or on engine error; on error it also flushes the queue.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
AW, 32, descriptor address width (src/dst/err_addr)
LW, 32, descriptor length width

Ports:
clk  in  1  clock
rstn  in  1  async reset, active-low
push_i  in  1  one-cycle go pulse from CSR block
push_last_i  in  1  descriptor is last of scatter list
push_src_i  in  AW  source address
push_dst_i  in  AW  destination address
push_len_i  in  LW  length
full_o  out  1  FIFO full
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
drop_o  out  1  one-cycle pulse: push discarded
desc_valid_o  out  1  descriptor offered to engine
desc_ready_i  in  1  engine accepts descriptor
desc_src_o  out  AW  offered source
desc_dst_o  out  AW  offered destination
desc_len_o  out  LW  offered length
desc_last_o  out  1  offered last flag
eng_done_i  in  1  one-cycle completion pulse from engine
eng_error_i  in  1  completion had error (qualified by eng_done_i)
eng_err_addr_i  in  AW  faulting address (qualified by eng_done_i)
busy_o  out  1  state != IDLE or FIFO non-empty
irq_o  out  1  sticky interrupt
irq_error_o  out  1  irq cause: 0 normal last, 1 error
err_addr_o  out  AW  latched faulting address
irq_clr_i  in  1  one-cycle clear from L1

Behaviour:
- Reset (async, rstn low):
  - FIFO empty; state IDLE.
  - All outputs 0, except level_o = 0 and full_o = 0.
- FIFO push:
  - A push is accepted when push_i is high and either level < DEPTH or a pop occurs in the same cycle.
  - Otherwise drop_o pulses for one cycle and the FIFO is unchanged.
  - In HALT, every push is dropped (drop_o pulses).
- FIFO pop: occurs in the cycle desc_valid_o && desc_ready_i.
- Pointers wrap modulo DEPTH.
- level_o and full_o are registered and reflect the previous cycle's push/pop.
- FSM states:
  - IDLE: if FIFO non-empty, load head into output registers -> ISSUE. Earliest desc_valid_o is the cycle after the push.
  - ISSUE: desc_valid_o = 1. desc_* are held stable until desc_ready_i. On handshake, pop and go to WAIT; desc_valid_o drops next cycle.
  - WAIT: wait for eng_done_i; outcome depends on error and last flags (below).
  - HALT: FIFO held empty; leave to IDLE on irq_clr_i.
- WAIT outcomes on eng_done_i:
  - eng_error_i = 1: set irq_o = 1 and irq_error_o = 1, latch err_addr_o <= eng_err_addr_i, flush FIFO (level 0 next cycle) -> HALT.
  - eng_error_i = 0 and issued descriptor had last = 1: set irq_o = 1, irq_error_o = 0 -> IDLE.
  - eng_error_i = 0 and last = 0: -> IDLE. The next descriptor is offered 2 cycles after done.
- eng_done_i outside WAIT is ignored.
- irq_clr_i clears irq_o and irq_error_o next cycle; err_addr_o holds its value until the next error.
- If irq set and irq_clr_i coincide, set wins.
- A new normal completion while irq_o is already set keeps irq_o = 1. irq_error_o only goes 0 -> 1 (error dominates) until cleared.
- busy_o is registered-equivalent: asserted from the cycle after an accepted push until IDLE with an empty FIFO.
- Only one descriptor is in flight at a time; no pipelining of issue and completion.

Test Plan:
- Single push src=0x1000 dst=0x2000 len=64 last=1, ready tied 1, done 5 cycles later -> desc_valid_o high exactly 1 cycle with those values; irq_o=1, irq_error_o=0 cycle after done; busy_o=0 after.
- Push 3 descriptors back-to-back, ready held 0 for 4 cycles -> desc_* stable across stall, level_o=3 then 2 after handshake; FIFO order preserved; irq only after the third (last=1) completes.
- Push DEPTH+1=9 descriptors with engine stalled -> full_o=1 after 8th; 9th gives drop_o pulse; level_o=8; push with simultaneous pop at full is accepted.
- Second of 4 descriptors completes with eng_error_i=1, eng_err_addr_i=0xDEAD0 -> irq_o=1, irq_error_o=1, err_addr_o=0xDEAD0; level_o=0; push in HALT drops; after irq_clr_i, new push is issued normally.
- irq_clr_i asserted in same cycle as a last-completion -> irq_o remains 1; clear one cycle later -> irq_o=0.
- rstn asserted during WAIT with 3 queued -> all outputs 0, level_o=0, state IDLE; late eng_done_i after reset ignored.

Source files
------------

// File: rtl/dma_desc_queue.sv
// Descriptor FIFO and single-in-flight issue sequencer between the DMA CSR
// front-end and the transfer engine, with sticky completion/error interrupt.
//
// state | meaning
// IDLE  | nothing offered; load FIFO head (or a bypassed push) when available
// ISSUE | descriptor offered on desc_*, held until desc_ready_i
// WAIT  | descriptor in flight, waiting for eng_done_i
// HALT  | engine error seen; queue flushed and pushes dropped until irq_clr_i
module dma_desc_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int LW    = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       push_last_i,
  input  logic [AW-1:0]              push_src_i,
  input  logic [AW-1:0]              push_dst_i,
  input  logic [LW-1:0]              push_len_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o,
  output logic                       desc_valid_o,
  input  logic                       desc_ready_i,
  output logic [AW-1:0]              desc_src_o,
  output logic [AW-1:0]              desc_dst_o,
  output logic [LW-1:0]              desc_len_o,
  output logic                       desc_last_o,
  input  logic                       eng_done_i,
  input  logic                       eng_error_i,
  input  logic [AW-1:0]              eng_err_addr_i,
  output logic                       busy_o,
  output logic                       irq_o,
  output logic                       irq_error_o,
  output logic [AW-1:0]              err_addr_o,
  input  logic                       irq_clr_i
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LVW = PW + 1;
  localparam int DW  = 2 * AW + LW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [LVW-1:0]  count, count_nxt;
  logic [DW-1:0]   push_word, head_word;
  logic            pop, err_hit, last_hit, push_acc, load, empty;

  assign empty     = (count == '0);
  assign pop       = (state == S_ISSUE) && desc_ready_i;
  assign err_hit   = (state == S_WAIT) && eng_done_i && eng_error_i;
  assign last_hit  = (state == S_WAIT) && eng_done_i && !eng_error_i && desc_last_o;
  // A slot frees up on the same edge as a pop, so a full FIFO still accepts then.
  assign push_acc  = push_i && (state != S_HALT) && !err_hit &&
                     ((count != LVW'(DEPTH)) || pop);
  assign load      = (state == S_IDLE) && (!empty || push_acc);
  assign push_word = {push_src_i, push_dst_i, push_len_i, push_last_i};
  // Empty FIFO in IDLE: bypass the push straight into the offer registers.
  assign head_word = empty ? push_word : mem[rptr];

  always_comb begin
    count_nxt = count;
    if (err_hit)
      count_nxt = '0;
    else if (push_acc && !pop)
      count_nxt = count + 1'b1;
    else if (!push_acc && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full_o  <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      if (push_acc)
        wptr <= wptr + 1'b1;
      if (err_hit)
        rptr <= wptr;
      else if (pop)
        rptr <= rptr + 1'b1;
      count  <= count_nxt;
      full_o <= (count_nxt == LVW'(DEPTH));
      drop_o <= push_i && !push_acc;
    end
  end

  assign level_o = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_ISSUE;
      S_ISSUE: if (desc_ready_i) state_nxt = S_WAIT;
      S_WAIT:  if (eng_done_i) state_nxt = eng_error_i ? S_HALT : S_IDLE;
      S_HALT:  if (irq_clr_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    desc_valid_o = (state == S_ISSUE);
    busy_o       = (state != S_IDLE) || !empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      desc_src_o  <= '0;
      desc_dst_o  <= '0;
      desc_len_o  <= '0;
      desc_last_o <= 1'b0;
    end else if (load) begin
      {desc_src_o, desc_dst_o, desc_len_o, desc_last_o} <= head_word;
    end
  end

  // Setting beats clearing; the error cause is sticky against later normal completions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_o       <= 1'b0;
      irq_error_o <= 1'b0;
      err_addr_o  <= '0;
    end else if (err_hit) begin
      irq_o       <= 1'b1;
      irq_error_o <= 1'b1;
      err_addr_o  <= eng_err_addr_i;
    end else if (last_hit) begin
      irq_o <= 1'b1;
      if (irq_clr_i)
        irq_error_o <= 1'b0;
    end else if (irq_clr_i) begin
      irq_o       <= 1'b0;
      irq_error_o <= 1'b0;
    end
  end

endmodule
